// File: rtl/wb_queue.sv
// Write-back queue: buffers register writes, drains one per cycle into the regfile write port, forwards pending data to reads.
// Latency: a push at edge N is presented on wren/wrad/wrdt during cycle N..N+1 and forwarded combinationally from edge N.
// Backpressure: in_ready drops while full; drain_en low holds the head and lets the queue fill.
module wb_queue #(
   parameter int DEPTH = 4,
   parameter int AW    = 4,
   parameter int DW    = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [AW-1:0]            in_addr,
   input  logic [DW-1:0]            in_data,
   input  logic                     drain_en,
   output logic                     wren,
   output logic [AW-1:0]            wrad,
   output logic [DW-1:0]            wrdt,
   input  logic [AW-1:0]            rd1ad,
   input  logic [AW-1:0]            rd2ad,
   input  logic [DW-1:0]            rf_rd1dt,
   input  logic [DW-1:0]            rf_rd2dt,
   output logic [DW-1:0]            rd1dt,
   output logic [DW-1:0]            rd2dt,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   // Entry storage; contents are qualified by the occupancy counter, so no reset needed.
   logic [AW-1:0] r_mem_addr [DEPTH];
   logic [DW-1:0] r_mem_data [DEPTH];

   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;

   logic          w_full;
   logic          w_empty;
   logic          w_push;
   logic          w_pop;

   // Entries re-ordered oldest (slot 0) to youngest, with a valid flag per slot.
   logic          w_slot_vld  [DEPTH];
   logic [AW-1:0] w_slot_addr [DEPTH];
   logic [DW-1:0] w_slot_data [DEPTH];

   assign w_full   = (r_count == FULL_CNT);
   assign w_empty  = (r_count == '0);

   // No push while full, even if the head pops this same edge.
   assign w_push   = in_valid && !w_full;
   assign w_pop    = !w_empty && drain_en;

   assign in_ready = !w_full;
   assign full     = w_full;
   assign empty    = w_empty;
   assign count    = r_count;

   // Head presentation to the register file write port; zeroed when nothing is pending.
   always_comb begin
      wren = w_pop;
      wrad = '0;
      wrdt = '0;
      if (!w_empty) begin
         wrad = r_mem_addr[r_rd_ptr];
         wrdt = r_mem_data[r_rd_ptr];
      end
   end

   // Capture the pushed request at the write pointer.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem_addr[r_wr_ptr] <= in_addr;
         r_mem_data[r_wr_ptr] <= in_data;
      end
   end

   // Pointer and occupancy bookkeeping; pointers wrap naturally at the power-of-two depth.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PW'(1);
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + CW'(1);
         end else if (!w_push && w_pop) begin
            r_count <= r_count - CW'(1);
         end
      end
   end

   // Unroll the circular buffer into age order; the head being written this cycle stays valid.
   always_comb begin
      for (int k = 0; k < DEPTH; k++) begin
         w_slot_vld[k]  = (CW'(k) < r_count);
         w_slot_addr[k] = r_mem_addr[r_rd_ptr + PW'(k)];
         w_slot_data[k] = r_mem_data[r_rd_ptr + PW'(k)];
      end
   end

   // Read forwarding: scan oldest to youngest so the youngest match wins; otherwise pass raw data.
   always_comb begin
      rd1dt = rf_rd1dt;
      rd2dt = rf_rd2dt;
      for (int k = 0; k < DEPTH; k++) begin
         if (w_slot_vld[k] && (w_slot_addr[k] == rd1ad)) begin
            rd1dt = w_slot_data[k];
         end
         if (w_slot_vld[k] && (w_slot_addr[k] == rd2ad)) begin
            rd2dt = w_slot_data[k];
         end
      end
   end

   // Occupancy must never exceed the queue depth.
   a_count_bound: assert property (@(posedge clk) disable iff (!reset) r_count <= FULL_CNT);

   // A write enable is only ever raised for a pending entry.
   a_wren_nonempty: assert property (@(posedge clk) disable iff (!reset) wren |-> !w_empty);

endmodule

// File: tb/tb_wb_queue.sv
// Directed bench for wb_queue: table of per-cycle vectors plus a hand-written asynchronous reset sequence.
// Inputs are driven just after the falling edge and outputs checked 1ns later, well clear of the rising edge.
// Any mismatch prints a FAIL line; one summary line is always printed at the end.
module tb_wb_queue;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  in_addr;
   logic [15:0] in_data;
   logic        drain_en;
   logic        wren;
   logic [3:0]  wrad;
   logic [15:0] wrdt;
   logic [3:0]  rd1ad;
   logic [3:0]  rd2ad;
   logic [15:0] rf_rd1dt;
   logic [15:0] rf_rd2dt;
   logic [15:0] rd1dt;
   logic [15:0] rd2dt;
   logic [2:0]  count;
   logic        full;
   logic        empty;

   int n_checks;
   int n_fail;

   wb_queue #(.DEPTH(4), .AW(4), .DW(16)) dut (
      .clk      (clk),
      .reset    (reset),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_addr  (in_addr),
      .in_data  (in_data),
      .drain_en (drain_en),
      .wren     (wren),
      .wrad     (wrad),
      .wrdt     (wrdt),
      .rd1ad    (rd1ad),
      .rd2ad    (rd2ad),
      .rf_rd1dt (rf_rd1dt),
      .rf_rd2dt (rf_rd2dt),
      .rd1dt    (rd1dt),
      .rd2dt    (rd2dt),
      .count    (count),
      .full     (full),
      .empty    (empty)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        vld;
      logic [3:0]  ad;
      logic [15:0] dt;
      logic        drn;
      logic [3:0]  r1a;
      logic [15:0] r1f;
      logic [3:0]  r2a;
      logic [15:0] r2f;
      logic        e_wren;
      logic [3:0]  e_wrad;
      logic [15:0] e_wrdt;
      logic [15:0] e_rd1;
      logic [15:0] e_rd2;
      logic [2:0]  e_cnt;
   } vec_t;

   localparam int NV = 24;
   vec_t vecs [NV];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic vld, input logic [3:0] ad, input logic [15:0] dt, input logic drn,
                        input logic [3:0] r1a, input logic [15:0] r1f, input logic [3:0] r2a, input logic [15:0] r2f);
      in_valid = vld;
      in_addr  = ad;
      in_data  = dt;
      drain_en = drn;
      rd1ad    = r1a;
      rf_rd1dt = r1f;
      rd2ad    = r2a;
      rf_rd2dt = r2f;
   endtask

   // Status flags follow from the expected occupancy.
   task automatic chk_status(input string tag, input logic [2:0] e_cnt);
      chk({tag, " count"},    32'(count),    32'(e_cnt));
      chk({tag, " full"},     32'(full),     32'(e_cnt == 3'd4));
      chk({tag, " empty"},    32'(empty),    32'(e_cnt == 3'd0));
      chk({tag, " in_ready"}, 32'(in_ready), 32'(e_cnt != 3'd4));
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish, got no end, expected end");
      $fatal(1, "timeout");
   end

   initial begin
      n_checks = 0;
      n_fail   = 0;

      // vld ad dt drn r1a r1f r2a r2f | wren wrad wrdt rd1 rd2 cnt
      // Single push then drain.
      vecs[0]  = '{1'b1, 4'h5, 16'hFEDC, 1'b1, 4'h5, 16'h0000, 4'h0, 16'h0000, 1'b0, 4'h0, 16'h0000, 16'h0000, 16'h0000, 3'd0};
      vecs[1]  = '{1'b0, 4'h0, 16'h0000, 1'b1, 4'h5, 16'h0000, 4'h3, 16'h1234, 1'b1, 4'h5, 16'hFEDC, 16'hFEDC, 16'h1234, 3'd1};
      vecs[2]  = '{1'b0, 4'h0, 16'h0000, 1'b1, 4'h5, 16'hFEDC, 4'h3, 16'h1234, 1'b0, 4'h0, 16'h0000, 16'hFEDC, 16'h1234, 3'd0};
      // Fill with drain held off, fifth request stalled, then drain in order.
      vecs[3]  = '{1'b1, 4'h0, 16'hFE00, 1'b0, 4'h0, 16'h0000, 4'h0, 16'h0000, 1'b0, 4'h0, 16'h0000, 16'h0000, 16'h0000, 3'd0};
      vecs[4]  = '{1'b1, 4'h1, 16'hFE01, 1'b0, 4'h0, 16'h0000, 4'h1, 16'h0000, 1'b0, 4'h0, 16'hFE00, 16'hFE00, 16'h0000, 3'd1};
      vecs[5]  = '{1'b1, 4'h2, 16'hFE02, 1'b0, 4'h1, 16'h0000, 4'h2, 16'h5555, 1'b0, 4'h0, 16'hFE00, 16'hFE01, 16'h5555, 3'd2};
      vecs[6]  = '{1'b1, 4'h3, 16'hFE03, 1'b0, 4'h2, 16'h0000, 4'h3, 16'h0000, 1'b0, 4'h0, 16'hFE00, 16'hFE02, 16'h0000, 3'd3};
      vecs[7]  = '{1'b1, 4'h4, 16'hFE04, 1'b0, 4'h3, 16'h0000, 4'h4, 16'h7777, 1'b0, 4'h0, 16'hFE00, 16'hFE03, 16'h7777, 3'd4};
      vecs[8]  = '{1'b1, 4'h4, 16'hFE04, 1'b1, 4'h4, 16'h7777, 4'h0, 16'h0000, 1'b1, 4'h0, 16'hFE00, 16'h7777, 16'hFE00, 3'd4};
      vecs[9]  = '{1'b1, 4'h4, 16'hFE04, 1'b1, 4'h0, 16'hFE00, 4'h3, 16'h0000, 1'b1, 4'h1, 16'hFE01, 16'hFE00, 16'hFE03, 3'd3};
      vecs[10] = '{1'b0, 4'h0, 16'h0000, 1'b1, 4'h4, 16'h0000, 4'h1, 16'hFE01, 1'b1, 4'h2, 16'hFE02, 16'hFE04, 16'hFE01, 3'd3};
      vecs[11] = '{1'b0, 4'h0, 16'h0000, 1'b1, 4'h2, 16'hFE02, 4'h3, 16'h0000, 1'b1, 4'h3, 16'hFE03, 16'hFE02, 16'hFE03, 3'd2};
      vecs[12] = '{1'b0, 4'h0, 16'h0000, 1'b1, 4'h4, 16'h0000, 4'h0, 16'hFE00, 1'b1, 4'h4, 16'hFE04, 16'hFE04, 16'hFE00, 3'd1};
      vecs[13] = '{1'b0, 4'h0, 16'h0000, 1'b1, 4'h4, 16'hFE04, 4'h0, 16'hFE00, 1'b0, 4'h0, 16'h0000, 16'hFE04, 16'hFE00, 3'd0};
      // Two writes to the same register: youngest forwarded, survives one pop.
      vecs[14] = '{1'b1, 4'h7, 16'h1111, 1'b0, 4'h7, 16'h0000, 4'h8, 16'hABCD, 1'b0, 4'h0, 16'h0000, 16'h0000, 16'hABCD, 3'd0};
      vecs[15] = '{1'b1, 4'h7, 16'h2222, 1'b0, 4'h7, 16'h0000, 4'h8, 16'hABCD, 1'b0, 4'h7, 16'h1111, 16'h1111, 16'hABCD, 3'd1};
      vecs[16] = '{1'b0, 4'h0, 16'h0000, 1'b0, 4'h7, 16'h0000, 4'h8, 16'hABCD, 1'b0, 4'h7, 16'h1111, 16'h2222, 16'hABCD, 3'd2};
      vecs[17] = '{1'b0, 4'h0, 16'h0000, 1'b1, 4'h7, 16'h0000, 4'h8, 16'hABCD, 1'b1, 4'h7, 16'h1111, 16'h2222, 16'hABCD, 3'd2};
      vecs[18] = '{1'b0, 4'h0, 16'h0000, 1'b0, 4'h7, 16'h1111, 4'h8, 16'hABCD, 1'b0, 4'h7, 16'h2222, 16'h2222, 16'hABCD, 3'd1};
      // Push while popping at count 2: count holds, order kept.
      vecs[19] = '{1'b1, 4'hA, 16'h000A, 1'b0, 4'hA, 16'h0000, 4'h9, 16'h0000, 1'b0, 4'h7, 16'h2222, 16'h0000, 16'h0000, 3'd1};
      vecs[20] = '{1'b1, 4'h9, 16'h0009, 1'b1, 4'hA, 16'h0000, 4'h9, 16'h0000, 1'b1, 4'h7, 16'h2222, 16'h000A, 16'h0000, 3'd2};
      vecs[21] = '{1'b0, 4'h0, 16'h0000, 1'b1, 4'h7, 16'h2222, 4'h9, 16'h0000, 1'b1, 4'hA, 16'h000A, 16'h2222, 16'h0009, 3'd2};
      vecs[22] = '{1'b0, 4'h0, 16'h0000, 1'b1, 4'hA, 16'h000A, 4'h9, 16'h0000, 1'b1, 4'h9, 16'h0009, 16'h000A, 16'h0009, 3'd1};
      vecs[23] = '{1'b0, 4'h0, 16'h0000, 1'b1, 4'h9, 16'h0009, 4'h0, 16'h0000, 1'b0, 4'h0, 16'h0000, 16'h0009, 16'h0000, 3'd0};

      // Reset state: requests and drain are asserted but must have no effect.
      reset = 1'b0;
      drive(1'b1, 4'h5, 16'h9999, 1'b1, 4'h5, 16'h1357, 4'h6, 16'h2468);
      @(negedge clk);
      @(negedge clk);
      #1;
      chk("reset wren", 32'(wren), 32'h0);
      chk("reset wrad", 32'(wrad), 32'h0);
      chk("reset wrdt", 32'(wrdt), 32'h0);
      chk("reset rd1dt", 32'(rd1dt), 32'h1357);
      chk("reset rd2dt", 32'(rd2dt), 32'h2468);
      chk_status("reset", 3'd0);
      @(negedge clk);
      reset = 1'b1;

      for (int i = 0; i < NV; i++) begin
         drive(vecs[i].vld, vecs[i].ad, vecs[i].dt, vecs[i].drn,
               vecs[i].r1a, vecs[i].r1f, vecs[i].r2a, vecs[i].r2f);
         #1;
         chk($sformatf("v%0d wren", i),  32'(wren),  32'(vecs[i].e_wren));
         chk($sformatf("v%0d wrad", i),  32'(wrad),  32'(vecs[i].e_wrad));
         chk($sformatf("v%0d wrdt", i),  32'(wrdt),  32'(vecs[i].e_wrdt));
         chk($sformatf("v%0d rd1dt", i), 32'(rd1dt), 32'(vecs[i].e_rd1));
         chk($sformatf("v%0d rd2dt", i), 32'(rd2dt), 32'(vecs[i].e_rd2));
         chk_status($sformatf("v%0d", i), vecs[i].e_cnt);
         @(negedge clk);
      end

      // Queue three writes, then assert reset in mid-cycle.
      drive(1'b1, 4'h1, 16'h0101, 1'b0, 4'h0, 16'h0000, 4'h0, 16'h0000);
      @(negedge clk);
      drive(1'b1, 4'h2, 16'h0202, 1'b0, 4'h0, 16'h0000, 4'h0, 16'h0000);
      @(negedge clk);
      drive(1'b1, 4'h6, 16'h0606, 1'b0, 4'h0, 16'h0000, 4'h0, 16'h0000);
      @(negedge clk);
      drive(1'b0, 4'h0, 16'h0000, 1'b1, 4'h1, 16'hBEEF, 4'h6, 16'h0000);
      #1;
      chk("pre-rst wren", 32'(wren), 32'h1);
      chk("pre-rst wrad", 32'(wrad), 32'h1);
      chk("pre-rst rd1dt", 32'(rd1dt), 32'h0101);
      chk("pre-rst rd2dt", 32'(rd2dt), 32'h0606);
      chk_status("pre-rst", 3'd3);
      #2;
      reset = 1'b0;
      #1;
      chk("mid-rst wren", 32'(wren), 32'h0);
      chk("mid-rst wrad", 32'(wrad), 32'h0);
      chk("mid-rst wrdt", 32'(wrdt), 32'h0);
      chk("mid-rst rd1dt", 32'(rd1dt), 32'hBEEF);
      chk("mid-rst rd2dt", 32'(rd2dt), 32'h0000);
      chk_status("mid-rst", 3'd0);
      @(negedge clk);

      // Release and push one fresh write; nothing stale may follow it.
      reset = 1'b1;
      drive(1'b1, 4'h3, 16'h0303, 1'b1, 4'h3, 16'h0000, 4'h1, 16'h0000);
      #1;
      chk("post-rst0 wren", 32'(wren), 32'h0);
      chk("post-rst0 rd1dt", 32'(rd1dt), 32'h0000);
      chk_status("post-rst0", 3'd0);
      @(negedge clk);
      drive(1'b0, 4'h0, 16'h0000, 1'b1, 4'h3, 16'h0000, 4'h1, 16'h0000);
      #1;
      chk("post-rst1 wren", 32'(wren), 32'h1);
      chk("post-rst1 wrad", 32'(wrad), 32'h3);
      chk("post-rst1 wrdt", 32'(wrdt), 32'h0303);
      chk("post-rst1 rd1dt", 32'(rd1dt), 32'h0303);
      chk("post-rst1 rd2dt", 32'(rd2dt), 32'h0000);
      chk_status("post-rst1", 3'd1);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         #1;
         chk($sformatf("post-rst%0d wren", c + 2), 32'(wren), 32'h0);
         chk($sformatf("post-rst%0d wrad", c + 2), 32'(wrad), 32'h0);
         chk_status($sformatf("post-rst%0d", c + 2), 3'd0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/wb_queue.md
# wb_queue

Write-back queue placed directly upstream of the 16x16 register file. Buffers register-write requests from the execute side in a small FIFO, drains them one per cycle into the register file's single write port (`wren`/`wrad`/`wrdt`), and forwards pending write data onto the two read ports so readers never see stale register contents.

## Interface
- `DEPTH`, 4: number of queue entries (power of two, ≥2).
- `AW`, 4: register address width.
- `DW`, 16: register data width.

- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  producer write request valid.
- `in_ready`  out  1  queue can accept a request.
- `in_addr`  in  AW  destination register.
- `in_data`  in  DW  data to write.
- `drain_en`  in  1  register file may accept a write this cycle.
- `wren`  out  1  write enable to register file.
- `wrad`  out  AW  write address to register file.
- `wrdt`  out  DW  write data to register file.
- `rd1ad`, `rd2ad`  in  AW  read addresses (shared with register file).
- `rf_rd1dt`, `rf_rd2dt`  in  DW  raw read data from register file.
- `rd1dt`, `rd2dt`  out  DW  forwarded read data.
- `count`  out  log2(DEPTH)+1  valid entries held.
- `full`, `empty`  out  1  status.

## Operation
- Storage: circular buffer of DEPTH {addr, data} entries, write pointer, read pointer, occupancy counter.
- Push: `in_valid && in_ready` at rising edge stores {`in_addr`,`in_data`} at write pointer; pointer increments, wraps DEPTH-1 → 0.
- `in_ready = !full`. No same-cycle push-when-full even if a pop occurs.
- Head presentation (combinational from state): `wren = !empty && drain_en`; `wrad`/`wrdt` = head entry when `!empty`, else 0.
- Pop: at rising edge when `wren` is 1; read pointer increments with wrap. Register file commits the same edge.
- Simultaneous push and pop: `count` unchanged, FIFO order preserved.
- `drain_en` low: no pop, `wren` 0, queue may fill.
- Forwarding, per read port independently: compare `rdNad` against every valid entry; if any match, `rdNdt` = data of the youngest matching entry (closest to write pointer); else `rdNdt = rf_rdNdt`. The head entry being written this cycle counts as valid (not yet committed). Address 0 is not special.
- Request arriving this cycle (`in_valid`) is not forwarded until pushed.
- `full = (count == DEPTH)`, `empty = (count == 0)`.
- Reset (`reset` low, async): pointers and `count` to 0; `empty`=1, `full`=0, `in_ready`=1, `wren`=0, `wrad`=0, `wrdt`=0; all entries invalid so `rdNdt = rf_rdNdt` immediately. Pending writes are discarded, never committed. Entry storage contents need not be cleared.

## Timing
- Push at edge N into empty queue with `drain_en`=1: `wren`=1 during cycle N→N+1, register file written at edge N+1. Write latency 1 cycle; throughput 1 write/cycle.
- Forwarding is combinational: new entry visible on `rdNdt` from edge N, continuously until register file holds it (edge N+1), with no gap.
- `in_ready`, `full`, `empty`, `count` update at the clock edge only (or asynchronously on reset).
- Reset release is synchronized externally; the first push may occur at the first edge with `reset` high.

## Test plan
- Reset, `drain_en`=1, push (5, 16'hFEDC): next cycle `wren`=1, `wrad`=5, `wrdt`=FEDC; with `rd1ad`=5, `rf_rd1dt`=0000 → `rd1dt`=FEDC; the following cycle `wren`=0, `empty`=1.
- `drain_en`=0, push addr 0..3 data FE00..FE03: `full`=1, `in_ready`=0, `count`=4, 5th request (4, FE04) held; raise `drain_en`: writes 0..3 in order on 4 consecutive cycles, `in_ready`=1 after the first pop, then FE04 accepted and written.
- `drain_en`=0, push (7, 1111) then (7, 2222): `rd1ad`=7 → 2222; `rd2ad`=8 with `rf_rd2dt`=ABCD → ABCD; after one pop `rd1dt` still 2222.
- `count`=2, `drain_en`=1, push (9, 0009) while popping: `count` stays 2, subsequent writes appear in push order.
- 3 entries pending, drive `reset` low mid-cycle: `wren`=0, `count`=0, `rd1dt`=`rf_rd1dt` immediately; after release, push (3, 0303) is written with 1-cycle latency and no stale entries ever appear on `wrad`.
